// File: rtl/ga_pkg.sv
// Shared constants and types for the GA accelerator datapath.
package ga_pkg;

  localparam int DATA_W      = 6;
  localparam int M_MAX       = 32;
  localparam int CHROM_MAX_W = DATA_W * M_MAX;

  // Upper bounds for population size, bit-precision and generation count,
  // and the register widths needed to hold them.
  localparam int P_MAX   = 64;
  localparam int B_MAX   = 16;
  localparam int G_MAX   = 1024;
  localparam int P_CNT_W = $clog2(P_MAX + 1);
  localparam int B_CNT_W = $clog2(B_MAX + 1);
  localparam int G_CNT_W = $clog2(G_MAX + 1);

  typedef logic [CHROM_MAX_W-1:0] chrom_t;

endpackage : ga_pkg

// File: rtl/ga_queue_mem.sv
// Register-array storage for GA queues: one synchronous write port and one
// combinational read port.
module ga_queue_mem #(
  parameter int W     = 192,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; the pointers and count define which
  // entries are meaningful, and leaving it out keeps it a plain register file.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : ga_queue_mem

// File: rtl/ga_chrom_queue.sv
// First-word-fall-through chromosome FIFO with sticky overflow/underflow
// flags, sitting between ga_init_pop and the fitness stage.
module ga_chrom_queue
  import ga_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int CNT_W    = $clog2(DEPTH + 1),
  parameter int AFULL_TH = DEPTH - 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sw_rst,
  input  logic             push,
  input  chrom_t           push_chromosome,
  input  logic             pop,
  output logic             pop_valid,
  output chrom_t           pop_chromosome,
  output logic             full,
  output logic             afull,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             ovf_err,
  output logic             udf_err
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             ovf_q,    ovf_d;
  logic             udf_q,    udf_d;

  logic   wr_en;
  logic   rd_en;
  logic   mem_we;
  chrom_t head;

  // A full queue still takes a push when the same cycle's pop frees a slot.
  assign wr_en  = push & (~full | pop);
  assign rd_en  = pop & ~empty;
  assign mem_we = wr_en & ~sw_rst;

  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (push & full & ~pop);
    udf_d    = udf_q | (pop & empty);

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (sw_rst) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  ga_queue_mem #(
    .W     (CHROM_MAX_W),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (push_chromosome),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  assign empty          = (count_q == '0);
  assign full           = (count_q == CNT_W'(DEPTH));
  assign afull          = (count_q >= CNT_W'(AFULL_TH));
  assign pop_valid      = ~empty;
  assign pop_chromosome = empty ? '0 : head;
  assign count          = count_q;
  assign ovf_err        = ovf_q;
  assign udf_err        = udf_q;

endmodule : ga_chrom_queue
